// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// Package : pid_pkg
// Default widths, integrator action encoding and saturation helpers.
// Rev     : 1.0
// ============================================================================
package pid_pkg;

  localparam int C_ERR_W    = 13;
  localparam int C_OUT_W    = 12;
  localparam int C_INT_W    = 18;
  localparam int C_DECIM_W  = 20;
  localparam int C_D_DLY    = 3;
  localparam int C_D_SAT_W  = 9;
  localparam int C_D_SHIFT  = 1;
  localparam int C_I_SHIFT  = 5;
  localparam int C_SLEW_MAX = 0;
  localparam int C_PIPE     = 2;

  typedef enum logic [1:0] {
    INT_CLEAR = 2'd0,
    INT_HOLD  = 2'd1,
    INT_ACC   = 2'd2
  } int_op_e;

  // Clamp a signed value into the range of a signed field of the given width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi)      return hi;
    else if (val < lo) return lo;
    else               return val;
  endfunction

  // Clamp a signed value into 0 .. 2^width-1.
  function automatic logic signed [31:0] clip_unsigned(input logic signed [31:0] val,
                                                       input int width);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< width) - 32'sd1;
    if (val < 32'sd0)   return 32'sd0;
    else if (val > lim) return lim;
    else                return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pid_decimator.sv
`default_nettype none
// ============================================================================
// Module : pid_decimator
// Free-running counter; strobes when the observed bits are all ones.
// Rev    : 1.0
// ============================================================================
module pid_decimator #(
  parameter int DECIM_W  = 20,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic tick_now,
  output logic tick
);

  // FAST_SIM only watches the low 15 bits so simulations tick every 32768 clk.
  localparam int TAP_W = FAST_SIM ? 15 : DECIM_W;

  logic [DECIM_W-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;

  always_comb begin
    cnt_d    = cnt_q + DECIM_W'(1);
    tick_now = &cnt_q[TAP_W-1:0];
    tick_d   = tick_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/pid_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module : pid_ctrl_param
// P + I + D drive magnitude with anti-windup, optional slew limit, pipelined out.
// Rev    : 1.0
// ============================================================================
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W    = C_ERR_W,
  parameter int OUT_W    = C_OUT_W,
  parameter int INT_W    = C_INT_W,
  parameter int DECIM_W  = C_DECIM_W,
  parameter bit FAST_SIM = 1'b0,
  parameter int D_DLY    = C_D_DLY,
  parameter int D_SAT_W  = C_D_SAT_W,
  parameter int D_SHIFT  = C_D_SHIFT,
  parameter int I_SHIFT  = C_I_SHIFT,
  parameter int SLEW_MAX = C_SLEW_MAX,
  parameter int PIPE     = C_PIPE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    not_pedaling,
  input  logic                    freeze_int,
  output logic [OUT_W-1:0]        drv_mag,
  output logic                    sat_hi,
  output logic                    sat_lo,
  output logic                    tick
);

  localparam int D_W   = D_SAT_W + D_SHIFT;
  localparam int IT_W  = INT_W - 1 - I_SHIFT;
  localparam int MAX_A = (ERR_W > OUT_W + 1) ? ERR_W : OUT_W + 1;
  localparam int MAX_T = (MAX_A > D_W) ? MAX_A : D_W;
  // Wide enough that the largest P, I and D peaks together can never wrap.
  localparam int SUM_W = MAX_T + 2;
  localparam logic signed [OUT_W:0] SLEW_LIM = (OUT_W + 1)'(SLEW_MAX);

  logic                      tick_now;
  logic signed [ERR_W-1:0]   hist_q [D_DLY];
  logic signed [ERR_W-1:0]   hist_d [D_DLY];
  logic [INT_W-1:0]          integ_q, integ_d;
  logic [OUT_W-1:0]          cmd_q, cmd_d;
  logic                      sat_hi_q, sat_hi_d;
  logic                      sat_lo_q, sat_lo_d;

  logic signed [ERR_W:0]     diff;
  logic signed [D_SAT_W-1:0] d_sat;
  logic signed [D_W-1:0]     d_term;
  logic [IT_W-1:0]           iterm;
  logic signed [SUM_W-1:0]   sum;
  logic [OUT_W-1:0]          target;
  logic signed [INT_W:0]     acc;
  logic signed [OUT_W:0]     cmd_delta;
  logic                      err_pos;
  int_op_e                   int_op;

  pid_decimator #(
    .DECIM_W  (DECIM_W),
    .FAST_SIM (FAST_SIM)
  ) u_decim (
    .clk      (clk),
    .rst      (rst),
    .tick_now (tick_now),
    .tick     (tick)
  );

  always_comb begin
    diff    = (ERR_W + 1)'(error) - (ERR_W + 1)'(hist_q[D_DLY-1]);
    d_sat   = D_SAT_W'(sat_signed(32'(diff), D_SAT_W));
    d_term  = D_W'(d_sat) <<< D_SHIFT;
    iterm   = integ_q[INT_W-2:I_SHIFT];
    sum     = SUM_W'(error) + $signed(SUM_W'(iterm)) + SUM_W'(d_term);
    sat_lo_d = sum[SUM_W-1];
    sat_hi_d = !sum[SUM_W-1] && (|sum[SUM_W-2:OUT_W]);
    target  = OUT_W'(clip_unsigned(32'(sum), OUT_W));
    err_pos = !error[ERR_W-1] && (|error);

    // Anti-windup: stop integrating further upward while already clipped high.
    acc = (INT_W + 1)'(error) + $signed({1'b0, integ_q});
    if (not_pedaling)
      int_op = INT_CLEAR;
    else if (!tick_now || freeze_int || (sat_hi_d && err_pos))
      int_op = INT_HOLD;
    else
      int_op = INT_ACC;

    case (int_op)
      INT_CLEAR: integ_d = '0;
      INT_ACC:   integ_d = INT_W'(clip_unsigned(32'(acc), INT_W - 1));
      default:   integ_d = integ_q;
    endcase

    for (int i = 0; i < D_DLY; i++) hist_d[i] = hist_q[i];
    if (tick_now) begin
      hist_d[0] = error;
      for (int i = 1; i < D_DLY; i++) hist_d[i] = hist_q[i-1];
    end

    cmd_delta = $signed({1'b0, target}) - $signed({1'b0, cmd_q});
    cmd_d     = cmd_q;
    if (SLEW_MAX == 0) begin
      cmd_d = target;
    end else if (tick_now) begin
      if (cmd_delta > SLEW_LIM)
        cmd_d = cmd_q + OUT_W'(SLEW_MAX);
      else if (cmd_delta < -SLEW_LIM)
        cmd_d = cmd_q - OUT_W'(SLEW_MAX);
      else
        cmd_d = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D_DLY; i++) hist_q[i] <= '0;
      integ_q  <= '0;
      cmd_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      integ_q  <= integ_d;
      cmd_q    <= cmd_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  // The command register is the first output stage; the flags ride alongside it.
  generate
    if (PIPE > 1) begin : g_pipe
      logic [OUT_W+1:0] pipe_q [PIPE-1];
      logic [OUT_W+1:0] pipe_d [PIPE-1];

      always_comb begin
        pipe_d[0] = {cmd_q, sat_hi_q, sat_lo_q};
        for (int i = 1; i < PIPE - 1; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign {drv_mag, sat_hi, sat_lo} = pipe_q[PIPE-2];
    end else begin : g_nopipe
      assign {drv_mag, sat_hi, sat_lo} = {cmd_q, sat_hi_q, sat_lo_q};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pid_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module : tb_pid_ctrl_param
// Two DUTs (no slew / slew 64) on a short decimation period against a model.
// Rev    : 1.0
// ============================================================================
module tb_pid_ctrl_param;

  localparam int ERR_W   = 13;
  localparam int OUT_W   = 12;
  localparam int DECIM_W = 6;
  localparam int PERIOD  = 64;
  localparam int D_DLY   = 3;
  localparam int SLEW1   = 64;
  localparam int I_MAX   = 131071;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [ERR_W-1:0] error;
  logic                    not_pedaling;
  logic                    freeze_int;
  logic [OUT_W-1:0]        drv0, drv1;
  logic                    hi0, lo0, tk0, hi1, lo1, tk1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, written with plain integer arithmetic.
  int m_cnt = 0;
  int m_integ = 0;
  int m_tick = 0;
  int m_hist [D_DLY];
  int m_cmd [2];
  int m_hi [2];
  int m_lo [2];
  int m_omag [2];
  int m_ohi [2];
  int m_olo [2];

  always #5 clk = ~clk;

  pid_ctrl_param #(.DECIM_W(DECIM_W), .FAST_SIM(0), .SLEW_MAX(0)) u_dut0 (
    .clk(clk), .rst(rst), .error(error), .not_pedaling(not_pedaling),
    .freeze_int(freeze_int), .drv_mag(drv0), .sat_hi(hi0), .sat_lo(lo0), .tick(tk0)
  );

  pid_ctrl_param #(.DECIM_W(DECIM_W), .FAST_SIM(0), .SLEW_MAX(SLEW1)) u_dut1 (
    .clk(clk), .rst(rst), .error(error), .not_pedaling(not_pedaling),
    .freeze_int(freeze_int), .drv_mag(drv1), .sat_hi(hi1), .sat_lo(lo1), .tick(tk1)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_integ = 0; m_tick = 0;
    for (int i = 0; i < D_DLY; i++) m_hist[i] = 0;
    for (int s = 0; s < 2; s++) begin
      m_cmd[s] = 0; m_hi[s] = 0; m_lo[s] = 0;
      m_omag[s] = 0; m_ohi[s] = 0; m_olo[s] = 0;
    end
  endtask

  task automatic model_step();
    int e, d, iterm, sum, target, hi, lo, acc, slew, delta, ncmd;
    bit tk_now;
    e      = int'(error);
    tk_now = (m_cnt == PERIOD - 1);
    d      = e - m_hist[D_DLY-1];
    if (d > 255) d = 255;
    else if (d < -256) d = -256;
    d      = d * 2;
    iterm  = m_integ / 32;
    sum    = e + iterm + d;
    lo     = (sum < 0) ? 1 : 0;
    hi     = (sum > 4095) ? 1 : 0;
    target = lo ? 0 : (hi ? 4095 : sum);
    if (not_pedaling) begin
      m_integ = 0;
    end else if (tk_now && !freeze_int && !(hi != 0 && e > 0)) begin
      acc = m_integ + e;
      m_integ = (acc < 0) ? 0 : ((acc > I_MAX) ? I_MAX : acc);
    end
    for (int s = 0; s < 2; s++) begin
      slew = (s == 0) ? 0 : SLEW1;
      m_omag[s] = m_cmd[s]; m_ohi[s] = m_hi[s]; m_olo[s] = m_lo[s];
      if (slew == 0) ncmd = target;
      else if (tk_now) begin
        delta = target - m_cmd[s];
        if (delta > slew) ncmd = m_cmd[s] + slew;
        else if (delta < -slew) ncmd = m_cmd[s] - slew;
        else ncmd = target;
      end else ncmd = m_cmd[s];
      m_cmd[s] = ncmd; m_hi[s] = hi; m_lo[s] = lo;
    end
    if (tk_now) begin
      for (int i = D_DLY - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = e;
    end
    m_cnt  = (m_cnt + 1) % PERIOD;
    m_tick = tk_now;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check_val("drv0", int'(drv0), m_omag[0]);
      check_val("hi0",  int'(hi0),  m_ohi[0]);
      check_val("lo0",  int'(lo0),  m_olo[0]);
      check_val("tick0", int'(tk0), m_tick);
      check_val("drv1", int'(drv1), m_omag[1]);
      check_val("hi1",  int'(hi1),  m_ohi[1]);
      check_val("lo1",  int'(lo1),  m_olo[1]);
      check_val("tick1", int'(tk1), m_tick);
    end
  end

  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * PERIOD + 8) begin
      @(negedge clk);
      cyc++;
      if (tk0) seen++;
    end
    check_val("tick_count", seen, n);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_drv0"}, int'(drv0), 0);
    check_val({tag, "_flags0"}, int'({hi0, lo0, tk0}), 0);
    check_val({tag, "_drv1"}, int'(drv1), 0);
    check_val({tag, "_flags1"}, int'({hi1, lo1, tk1}), 0);
  endtask

  initial begin
    rst = 1'b1; error = 13'sd500; not_pedaling = 1'b0; freeze_int = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Integrator ramp from reset with a constant error of 32.
    rst = 1'b0; error = 13'sd32;
    wait_ticks(10);
    repeat (3) @(negedge clk);
    check_val("i_ramp", int'(drv0), 42);
    not_pedaling = 1'b1;
    repeat (3) @(negedge clk);
    check_val("i_clear", int'(drv0), 32);

    // P + D step with the integrator held at zero.
    error = 13'sd0;
    wait_ticks(3);
    repeat (2) @(negedge clk);
    error = 13'sd100;
    repeat (2) @(negedge clk);
    check_val("pd_step", int'(drv0), 300);
    wait_ticks(3);
    repeat (3) @(negedge clk);
    check_val("pd_settle", int'(drv0), 100);

    // Low clamp.
    not_pedaling = 1'b0; error = -13'sd4096;
    wait_ticks(5);
    repeat (3) @(negedge clk);
    check_val("lo_drv", int'(drv0), 0);
    check_val("lo_flag", int'(lo0), 1);

    // High clamp with anti-windup.
    error = 13'sd4095;
    wait_ticks(8);
    repeat (3) @(negedge clk);
    check_val("hi_drv", int'(drv0), 4095);
    check_val("hi_flag", int'(hi0), 1);
    error = 13'sd0;
    wait_ticks(3);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-run clears outputs before the next edge.
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);

    // Slew-limited step on the second instance.
    rst = 1'b0; not_pedaling = 1'b1; error = 13'sd1000;
    for (int k = 1; k <= 16; k++) begin
      wait_ticks(1);
      repeat (2) @(negedge clk);
      check_val($sformatf("slew_k%0d", k), int'(drv1), (64 * k > 1000) ? 1000 : 64 * k);
      check_val("slew_flags", int'({hi1, lo1}), 0);
    end

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: error = ERR_W'($urandom_range(0, 8191));
        1: error = ERR_W'(int'($urandom_range(0, 128)) - 64);
        2: error = ($urandom_range(0, 1) == 0) ? 13'sd4095 : -13'sd4096;
        default: ;
      endcase
      if ($urandom_range(0, 99) < 4) not_pedaling = ~not_pedaling;
      if ($urandom_range(0, 99) < 4) freeze_int = ~freeze_int;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
